// File: rtl/inert_burst_rdr_if.sv
`timescale 1ns/1ps
// SPI monarch handshake: the reader issues wrt/cmd, the monarch answers with done/rd_data.
interface inert_burst_rdr_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [7:0]  rd_data;

  modport master (output wrt, cmd, input done, rd_data);
  modport slave  (input wrt, cmd, output done, rd_data);
endinterface

// File: rtl/inert_burst_rdr.sv
`timescale 1ns/1ps
// Inertial sensor reader: power-on wait, three config writes, then one burst read of
// every channel per INT assertion, published atomically with an overrun indication.
module inert_burst_rdr #(
  parameter int          NUM_CH    = 6,
  parameter logic [7:0]  BASE_ADDR = 8'h22,
  parameter bit          FAST_SIM  = 1'b1,
  parameter logic [15:0] INIT_CMD0 = 16'h0D02,
  parameter logic [15:0] INIT_CMD1 = 16'h1160,
  parameter logic [15:0] INIT_CMD2 = 16'h1440
) (
  input  logic                    clk,
  input  logic                    rst_n,
  inert_burst_rdr_if.master       spi,
  input  logic                    INT,
  output logic [16*NUM_CH-1:0]    rdings,
  output logic                    vld,
  output logic                    init_done,
  output logic                    ovr
);

  localparam int          NB       = 2 * NUM_CH;
  localparam logic [3:0]  LAST_K   = 4'(NB - 1);
  localparam logic [15:0] PWR_LAST = FAST_SIM ? 16'd1023 : 16'hFFFF;

  localparam logic [2:0] PWR_WAIT = 3'd0;
  localparam logic [2:0] INIT_WR  = 3'd1;
  localparam logic [2:0] INIT_WT  = 3'd2;
  localparam logic [2:0] IDLE     = 3'd3;
  localparam logic [2:0] RD_WR    = 3'd4;
  localparam logic [2:0] RD_WT    = 3'd5;
  localparam logic [2:0] PUBLISH  = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic [3:0]            k_q, k_d;
  logic                  ovf_q, ovf_d;
  logic                  init_done_q, init_done_d;
  logic                  wrt_q, wrt_d;
  logic [15:0]           cmd_q, cmd_d;
  logic                  vld_q, vld_d;
  logic                  ovr_q, ovr_d;
  logic [16*NUM_CH-1:0]  rdings_q, rdings_d;
  logic [7:0]            shadow_q [NB];
  logic [7:0]            shadow_d [NB];
  logic [16*NUM_CH-1:0]  shadow_flat;
  logic                  int_meta_q, int_s_q, int_dly_q;
  logic                  int_rise;

  function automatic logic [15:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return INIT_CMD0;
      2'd1:    return INIT_CMD1;
      default: return INIT_CMD2;
    endcase
  endfunction

  assign int_rise = int_s_q & ~int_dly_q;

  always_comb begin : next_state
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    k_d         = k_q;
    ovf_d       = ovf_q;
    init_done_d = init_done_q;
    shadow_d    = shadow_q;
    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d = INIT_WR;
          idx_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      INIT_WR: state_d = INIT_WT;
      INIT_WT: begin
        if (spi.done) begin
          if (idx_q == 2'd2) begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = INIT_WR;
          end
        end
      end
      IDLE: begin
        if (int_s_q) begin
          k_d     = 4'd0;
          ovf_d   = 1'b0;
          state_d = RD_WR;
        end
      end
      RD_WR: begin
        if (int_rise) ovf_d = 1'b1;
        state_d = RD_WT;
      end
      RD_WT: begin
        if (int_rise) ovf_d = 1'b1;
        if (spi.done) begin
          for (int b = 0; b < NB; b++) begin
            if (k_q == 4'(b)) shadow_d[b] = spi.rd_data;
          end
          if (k_q == LAST_K) begin
            state_d = PUBLISH;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = RD_WR;
          end
        end
      end
      PUBLISH: state_d = IDLE;
      default: state_d = PWR_WAIT;
    endcase
  end

  // Outputs are registered from the next state so wrt/cmd/vld line up with the state they belong to.
  always_comb begin : outputs_next
    wrt_d = (state_d == INIT_WR) || (state_d == RD_WR);
    cmd_d = 16'h0000;
    if ((state_d == INIT_WR) || (state_d == INIT_WT)) begin
      cmd_d = init_cmd(idx_d);
    end else if ((state_d == RD_WR) || (state_d == RD_WT)) begin
      cmd_d = {1'b1, BASE_ADDR[6:0] + {3'b000, k_d}, 8'h00};
    end
    vld_d    = (state_d == PUBLISH);
    ovr_d    = vld_d & ovf_d;
    rdings_d = vld_d ? shadow_flat : rdings_q;
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pack
      assign shadow_flat[16*gi +: 16] = {shadow_d[2*gi+1], shadow_d[2*gi]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      k_q         <= '0;
      ovf_q       <= 1'b0;
      init_done_q <= 1'b0;
      wrt_q       <= 1'b0;
      cmd_q       <= '0;
      vld_q       <= 1'b0;
      ovr_q       <= 1'b0;
      rdings_q    <= '0;
      shadow_q    <= '{default: '0};
      int_meta_q  <= 1'b0;
      int_s_q     <= 1'b0;
      int_dly_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      ovf_q       <= ovf_d;
      init_done_q <= init_done_d;
      wrt_q       <= wrt_d;
      cmd_q       <= cmd_d;
      vld_q       <= vld_d;
      ovr_q       <= ovr_d;
      rdings_q    <= rdings_d;
      shadow_q    <= shadow_d;
      int_meta_q  <= INT;
      int_s_q     <= int_meta_q;
      int_dly_q   <= int_s_q;
    end
  end

  assign spi.wrt   = wrt_q;
  assign spi.cmd   = cmd_q;
  assign rdings    = rdings_q;
  assign vld       = vld_q;
  assign init_done = init_done_q;
  assign ovr       = ovr_q;

endmodule
